// File: rtl/mips_cpu_pkg.sv
// Shared types and defaults for the MIPS CPU front end.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pc_ctrl_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/mips_cpu_pc_unit.sv
// Program-counter unit: sequential/branch/jump/jr redirects with one branch delay slot,
// stall, halt-on-address and sticky misaligned-target detection.
module mips_cpu_pc_unit
    import mips_cpu_pkg::*;
#(
    parameter int unsigned          ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]    RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter logic [ADDR_W-1:0]    HALT_ADDR    = ADDR_W'(DEFAULT_HALT_ADDR),
    parameter int unsigned          INC          = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        pc_ctrl,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] link_addr,
    output logic              in_delay_slot,
    output logic              active,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] INC_VAL    = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = INC_VAL - 1'b1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              pend_vld_q, pend_vld_d;
    logic              delay_slot_q, delay_slot_d;
    logic              active_q, active_d;
    logic              addr_err_q, addr_err_d;

    pc_ctrl_t          ctrl;
    logic [ADDR_W-1:0] req_tgt;
    logic              misaligned;

    assign ctrl       = pc_ctrl_t'(pc_ctrl);
    assign req_tgt    = (ctrl == PC_JR) ? reg_target : branch_target;
    assign misaligned = |(req_tgt & ALIGN_MASK);

    always_comb begin
        pc_d         = pc_q;
        pend_tgt_d   = pend_tgt_q;
        pend_vld_d   = pend_vld_q;
        delay_slot_d = delay_slot_q;
        active_d     = active_q;
        addr_err_d   = addr_err_q;

        if (en && active_q) begin
            if (pend_vld_q) begin
                // Delay slot retires: take the stored target, ignore any new request.
                pc_d         = pend_tgt_q;
                pend_vld_d   = 1'b0;
                delay_slot_d = 1'b0;
            end else begin
                pc_d = pc_q + INC_VAL;
                if (ctrl != PC_SEQ) begin
                    if (misaligned) begin
                        addr_err_d = 1'b1;
                        active_d   = 1'b0;
                    end else begin
                        delay_slot_d = 1'b1;
                        pend_vld_d   = 1'b1;
                        pend_tgt_d   = req_tgt;
                    end
                end
            end
            if (pc_d == HALT_ADDR) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_VECTOR;
            pend_tgt_q   <= '0;
            pend_vld_q   <= 1'b0;
            delay_slot_q <= 1'b0;
            active_q     <= 1'b1;
            addr_err_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_tgt_q   <= pend_tgt_d;
            pend_vld_q   <= pend_vld_d;
            delay_slot_q <= delay_slot_d;
            active_q     <= active_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign pc_out        = pc_q;
    assign link_addr     = pc_q + (INC_VAL << 1);
    assign in_delay_slot = delay_slot_q;
    assign active        = active_q;
    assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_mips_cpu_pc_unit.sv
// Scoreboard bench for mips_cpu_pc_unit: expected state queued per driven edge, compared after it.
module tb_mips_cpu_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pc_ctrl = 2'd0;
    logic [31:0] branch_target = '0;
    logic [31:0] reg_target = '0;

    logic [31:0] pc_out, link_addr;
    logic        in_delay_slot, active, addr_err;
    logic [31:0] w_pc_out, w_link_addr;
    logic        w_in_delay_slot, w_active, w_addr_err;

    typedef struct {
        logic [31:0] pc;
        logic        ds;
        logic        act;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mips_cpu_pc_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .pc_ctrl       (pc_ctrl),
        .branch_target (branch_target),
        .reg_target    (reg_target),
        .pc_out        (pc_out),
        .link_addr     (link_addr),
        .in_delay_slot (in_delay_slot),
        .active        (active),
        .addr_err      (addr_err)
    );

    mips_cpu_pc_unit #(
        .ADDR_W       (32),
        .RESET_VECTOR (32'hFFFF_FFFC),
        .HALT_ADDR    (32'h0000_0000),
        .INC          (4)
    ) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .pc_ctrl       (pc_ctrl),
        .branch_target (branch_target),
        .reg_target    (reg_target),
        .pc_out        (w_pc_out),
        .link_addr     (w_link_addr),
        .in_delay_slot (w_in_delay_slot),
        .active        (w_active),
        .addr_err      (w_addr_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input exp_t e);
        check_eq({tag, ".pc"},   pc_out, e.pc);
        check_eq({tag, ".link"}, link_addr, e.pc + 32'd8);
        check_eq({tag, ".ds"},   32'(in_delay_slot), 32'(e.ds));
        check_eq({tag, ".act"},  32'(active), 32'(e.act));
        check_eq({tag, ".err"},  32'(addr_err), 32'(e.err));
    endtask

    // Drive one edge's inputs, queue its expected outcome, then compare after the edge.
    task automatic step(input string tag, input logic e, input logic [1:0] c,
                        input logic [31:0] bt, input logic [31:0] rt,
                        input logic [31:0] x_pc, input logic x_ds, input logic x_act,
                        input logic x_err);
        exp_t e_in, e_out;
        en            = e;
        pc_ctrl       = c;
        branch_target = bt;
        reg_target    = rt;
        e_in.pc = x_pc; e_in.ds = x_ds; e_in.act = x_act; e_in.err = x_err;
        sb.push_back(e_in);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e_out = sb.pop_front();
            check_state(tag, e_out);
        end
        en      = 1'b0;
        pc_ctrl = 2'd0;
    endtask

    task automatic do_reset(input string tag);
        exp_t r;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        r.pc = 32'hBFC0_0000; r.ds = 1'b0; r.act = 1'b1; r.err = 1'b0;
        check_state({tag, ".rst"}, r);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [31:0] RV = 32'hBFC0_0000;

    initial begin
        // 1 reset and sequential fetch
        do_reset("t1");
        step("t1.s1", 1, 2'd0, 0, 0, RV + 4,  0, 1, 0);
        step("t1.s2", 1, 2'd0, 0, 0, RV + 8,  0, 1, 0);
        step("t1.s3", 1, 2'd0, 0, 0, RV + 12, 0, 1, 0);

        // 2 taken branch through delay slot
        do_reset("t2");
        step("t2.ds",  1, 2'd1, 32'hBFC0_0100, 0, RV + 4,        1, 1, 0);
        step("t2.tgt", 1, 2'd0, 0,             0, 32'hBFC0_0100, 0, 1, 0);
        step("t2.seq", 1, 2'd0, 0,             0, 32'hBFC0_0104, 0, 1, 0);

        // 3 jump held in delay slot is ignored
        do_reset("t3");
        step("t3.ds",  1, 2'd2, 32'hBFC0_0200, 0, RV + 4,        1, 1, 0);
        step("t3.tgt", 1, 2'd2, 32'hBFC0_0200, 0, 32'hBFC0_0200, 0, 1, 0);
        step("t3.seq", 1, 2'd0, 0,             0, 32'hBFC0_0204, 0, 1, 0);

        // 4 stall in the delay slot keeps the pending target
        do_reset("t4");
        step("t4.ds", 1, 2'd1, 32'hBFC0_0300, 0, RV + 4, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step("t4.stall", 0, 2'd2, 32'h1234_5670, 32'h0, RV + 4, 1, 1, 0);
        end
        step("t4.tgt", 1, 2'd0, 0, 0, 32'hBFC0_0300, 0, 1, 0);
        step("t4.seq", 1, 2'd0, 0, 0, 32'hBFC0_0304, 0, 1, 0);

        // 5 jump-register to the halt address
        do_reset("t5");
        step("t5.ds",    1, 2'd3, 32'hBFC0_0400, 32'h0, RV + 4, 1, 1, 0);
        step("t5.halt",  1, 2'd0, 0, 0, 32'h0, 0, 0, 0);
        step("t5.frz1",  1, 2'd1, 32'hBFC0_0500, 0, 32'h0, 0, 0, 0);
        step("t5.frz2",  1, 2'd0, 0, 0, 32'h0, 0, 0, 0);

        // 6 misaligned branch target freezes, async reset recovers
        do_reset("t6");
        step("t6.mis",  1, 2'd1, 32'hBFC0_0102, 0, RV + 4, 0, 0, 1);
        step("t6.frz",  1, 2'd0, 0, 0, RV + 4, 0, 0, 1);
        do_reset("t6b");
        step("t6.run",  1, 2'd0, 0, 0, RV + 4, 0, 1, 0);
        // misaligned register target with the other low bit
        step("t6.jr",   1, 2'd3, 32'hBFC0_0800, 32'hBFC0_0901, RV + 8, 0, 0, 1);

        // 7 wrap to the halt address on the alternate instance
        do_reset("t7");
        check_eq("t7.w_rst_pc",  w_pc_out, 32'hFFFF_FFFC);
        check_eq("t7.w_rst_act", 32'(w_active), 32'd1);
        check_eq("t7.w_link",    w_link_addr, 32'h0000_0004);
        step("t7.main", 1, 2'd0, 0, 0, RV + 4, 0, 1, 0);
        check_eq("t7.w_pc",  w_pc_out, 32'h0);
        check_eq("t7.w_act", 32'(w_active), 32'd0);
        check_eq("t7.w_ds",  32'(w_in_delay_slot), 32'd0);

        // 8 reset mid-redirect discards the pending target
        do_reset("t8");
        step("t8.ds", 1, 2'd1, 32'hBFC0_0700, 0, RV + 4, 1, 1, 0);
        do_reset("t8b");
        step("t8.seq", 1, 2'd0, 0, 0, RV + 4, 0, 1, 0);
        step("t8.seq2", 1, 2'd0, 0, 0, RV + 8, 0, 1, 0);

        check_eq("sb.drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
